// File: rtl/k8088_memctl.sv
// Memory-side responder for the k8088 CPU bus: internal boot ROM, external async SRAM
// with programmable wait states, and a single-entry read latch that serves repeat reads.
module k8088_memctl #(
   parameter int unsigned SRAM_WAIT  = 2,
   parameter logic [3:0]  ROM_NIBBLE = 4'hF
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [19:0] cpu_address,
   input  logic [7:0]  cpu_out,
   input  logic        cpu_we,
   output logic [7:0]  cpu_in,
   output logic        chipen,
   output logic [15:0] rom_addr,
   input  logic [7:0]  rom_q,
   output logic [19:0] sram_addr,
   output logic [7:0]  sram_dout,
   input  logic [7:0]  sram_din,
   output logic        sram_we_n,
   output logic        sram_oe_n
);

   localparam int unsigned ADDR_W = 20;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned ROM_W  = 16;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [1:0] {IDLE, ROM_RD, SRAM_RD, SRAM_WR} state_t;

   state_t              state_q, state_d;
   logic                tag_valid_q, tag_valid_d;
   logic [ADDR_W-1:0]   tag_addr_q, tag_addr_d;
   logic [DATA_W-1:0]   tag_data_q, tag_data_d;
   logic                wr_done_q, wr_done_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                sram_we_n_q, sram_we_n_d;
   logic                sram_oe_n_q, sram_oe_n_d;
   logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
   logic [DATA_W-1:0]   sram_dout_q, sram_dout_d;
   logic [ROM_W-1:0]    rom_addr_q, rom_addr_d;

   logic rom_sel_c;
   logic hit_c;

   assign rom_sel_c = (cpu_address[19:16] == ROM_NIBBLE);
   assign hit_c     = tag_valid_q && (cpu_address == tag_addr_q);

   // CPU advances only from IDLE: a finished write or a latch hit
   assign chipen = reset_n && (state_q == IDLE) &&
                   ((cpu_we && wr_done_q) || (!cpu_we && hit_c));

   assign cpu_in    = tag_data_q;
   assign rom_addr  = rom_addr_q;
   assign sram_addr = sram_addr_q;
   assign sram_dout = sram_dout_q;
   assign sram_we_n = sram_we_n_q;
   assign sram_oe_n = sram_oe_n_q;

   // Next-state and datapath updates
   always_comb begin
      state_d     = state_q;
      tag_valid_d = tag_valid_q;
      tag_addr_d  = tag_addr_q;
      tag_data_d  = tag_data_q;
      wr_done_d   = wr_done_q;
      cnt_d       = cnt_q;
      sram_we_n_d = sram_we_n_q;
      sram_oe_n_d = sram_oe_n_q;
      sram_addr_d = sram_addr_q;
      sram_dout_d = sram_dout_q;
      rom_addr_d  = rom_addr_q;

      case (state_q)
         IDLE: begin
            if (cpu_we) begin
               if (wr_done_q) begin
                  wr_done_d = 1'b0;
               end else if (rom_sel_c) begin
                  // ROM is read-only; the write is acknowledged and dropped
                  wr_done_d = 1'b1;
               end else begin
                  sram_addr_d = cpu_address;
                  sram_dout_d = cpu_out;
                  sram_we_n_d = 1'b0;
                  cnt_d       = CNT_W'(SRAM_WAIT - 1);
                  state_d     = SRAM_WR;
               end
            end else if (!hit_c) begin
               tag_addr_d  = cpu_address;
               tag_valid_d = 1'b0;
               if (rom_sel_c) begin
                  rom_addr_d = cpu_address[15:0];
                  state_d    = ROM_RD;
               end else begin
                  sram_addr_d = cpu_address;
                  sram_oe_n_d = 1'b0;
                  cnt_d       = CNT_W'(SRAM_WAIT - 1);
                  state_d     = SRAM_RD;
               end
            end
         end
         ROM_RD: begin
            tag_data_d  = rom_q;
            tag_valid_d = 1'b1;
            state_d     = IDLE;
         end
         SRAM_RD: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               tag_data_d  = sram_din;
               tag_valid_d = 1'b1;
               sram_oe_n_d = 1'b1;
               state_d     = IDLE;
            end
         end
         SRAM_WR: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               sram_we_n_d = 1'b1;
               wr_done_d   = 1'b1;
               state_d     = IDLE;
               // Keep the read latch coherent with the byte just written
               if (tag_valid_q && (sram_addr_q == tag_addr_q)) begin
                  tag_data_d = sram_dout_q;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         tag_valid_q <= 1'b0;
         tag_addr_q  <= '0;
         tag_data_q  <= '0;
         wr_done_q   <= 1'b0;
         cnt_q       <= '0;
         sram_we_n_q <= 1'b1;
         sram_oe_n_q <= 1'b1;
         sram_addr_q <= '0;
         sram_dout_q <= '0;
         rom_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         tag_valid_q <= tag_valid_d;
         tag_addr_q  <= tag_addr_d;
         tag_data_q  <= tag_data_d;
         wr_done_q   <= wr_done_d;
         cnt_q       <= cnt_d;
         sram_we_n_q <= sram_we_n_d;
         sram_oe_n_q <= sram_oe_n_d;
         sram_addr_q <= sram_addr_d;
         sram_dout_q <= sram_dout_d;
         rom_addr_q  <= rom_addr_d;
      end
   end

endmodule

// File: tb/tb_k8088_memctl.sv
// Directed bench for k8088_memctl: per-cycle vector table plus hand-written reset-abort sequence.
module tb_k8088_memctl;

   logic        clock;
   logic        reset_n;
   logic [19:0] cpu_address;
   logic [7:0]  cpu_out;
   logic        cpu_we;
   logic [7:0]  cpu_in;
   logic        chipen;
   logic [15:0] rom_addr;
   logic [7:0]  rom_q;
   logic [19:0] sram_addr;
   logic [7:0]  sram_dout;
   logic [7:0]  sram_din;
   logic        sram_we_n;
   logic        sram_oe_n;

   int tests;
   int fails;
   logic mon_en;

   typedef struct {
      logic        rst_n;
      logic [19:0] addr;
      logic        we;
      logic [7:0]  wdata;
      logic [7:0]  din;
      logic [7:0]  romq;
      logic        e_chipen;
      logic [7:0]  e_cpu_in;
      logic        e_we_n;
      logic        e_oe_n;
      logic        chk_bus;
      logic [19:0] e_saddr;
      logic [7:0]  e_sdout;
      logic [15:0] e_raddr;
   } vec_t;

   vec_t vecs[$];

   k8088_memctl #(.SRAM_WAIT(2), .ROM_NIBBLE(4'hF)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .cpu_address (cpu_address),
      .cpu_out     (cpu_out),
      .cpu_we      (cpu_we),
      .cpu_in      (cpu_in),
      .chipen      (chipen),
      .rom_addr    (rom_addr),
      .rom_q       (rom_q),
      .sram_addr   (sram_addr),
      .sram_dout   (sram_dout),
      .sram_din    (sram_din),
      .sram_we_n   (sram_we_n),
      .sram_oe_n   (sram_oe_n)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Write strobe and output enable must never overlap
   always @(negedge clock) begin
      if (mon_en) begin
         tests++;
         if (sram_we_n === 1'b0 && sram_oe_n === 1'b0) begin
            fails++;
            $display("FAIL strobe_overlap: we_n=%b oe_n=%b expected not both 0 (t=%0t)",
                     sram_we_n, sram_oe_n, $time);
         end
      end
   end

   task automatic add(input logic r, input logic [19:0] a, input logic w, input logic [7:0] wd,
                      input logic [7:0] di, input logic [7:0] rq, input logic ce,
                      input logic [7:0] ci, input logic wen, input logic oen);
      vec_t v;
      v.rst_n = r;  v.addr = a;  v.we = w;  v.wdata = wd;  v.din = di;  v.romq = rq;
      v.e_chipen = ce;  v.e_cpu_in = ci;  v.e_we_n = wen;  v.e_oe_n = oen;
      v.chk_bus = 1'b0;  v.e_saddr = '0;  v.e_sdout = '0;  v.e_raddr = '0;
      vecs.push_back(v);
   endtask

   task automatic add_bus(input logic r, input logic [19:0] a, input logic w, input logic [7:0] wd,
                          input logic [7:0] di, input logic [7:0] rq, input logic ce,
                          input logic [7:0] ci, input logic wen, input logic oen,
                          input logic [19:0] sa, input logic [7:0] sd, input logic [15:0] ra);
      vec_t v;
      v.rst_n = r;  v.addr = a;  v.we = w;  v.wdata = wd;  v.din = di;  v.romq = rq;
      v.e_chipen = ce;  v.e_cpu_in = ci;  v.e_we_n = wen;  v.e_oe_n = oen;
      v.chk_bus = 1'b1;  v.e_saddr = sa;  v.e_sdout = sd;  v.e_raddr = ra;
      vecs.push_back(v);
   endtask

   initial begin
      int n;
      int wlow;
      tests  = 0;
      fails  = 0;
      mon_en = 1'b0;

      // Reset, then miss-read 0x12345
      add_bus(0, 20'h12345, 1, 8'h99, 8'hA5, 8'h00, 0, 8'h00, 1, 1, 20'h00000, 8'h00, 16'h0000);
      add    (1, 20'h12345, 0, 8'h00, 8'hA5, 8'h00, 0, 8'h00, 1, 1);
      add_bus(1, 20'h12345, 0, 8'h00, 8'hA5, 8'h00, 0, 8'h00, 1, 0, 20'h12345, 8'h00, 16'h0000);
      add    (1, 20'h12345, 0, 8'h00, 8'hA5, 8'h00, 0, 8'h00, 1, 0);
      add    (1, 20'h12345, 0, 8'h00, 8'hA5, 8'h00, 1, 8'hA5, 1, 1);
      add    (1, 20'h12345, 0, 8'h00, 8'h3C, 8'h00, 1, 8'hA5, 1, 1);
      // SRAM write 0x5A -> 0x00400
      add    (1, 20'h00400, 1, 8'h5A, 8'h3C, 8'h00, 0, 8'hA5, 1, 1);
      add_bus(1, 20'h00400, 1, 8'h5A, 8'h3C, 8'h00, 0, 8'hA5, 0, 1, 20'h00400, 8'h5A, 16'h0000);
      add_bus(1, 20'h00400, 1, 8'h5A, 8'h3C, 8'h00, 0, 8'hA5, 0, 1, 20'h00400, 8'h5A, 16'h0000);
      add_bus(1, 20'h00400, 1, 8'h5A, 8'h3C, 8'h00, 1, 8'hA5, 1, 1, 20'h00400, 8'h5A, 16'h0000);
      // Read back 0x00400 is a miss; SRAM returns 0x11
      add    (1, 20'h00400, 0, 8'h00, 8'h11, 8'h00, 0, 8'hA5, 1, 1);
      add    (1, 20'h00400, 0, 8'h00, 8'h11, 8'h00, 0, 8'hA5, 1, 0);
      add    (1, 20'h00400, 0, 8'h00, 8'h11, 8'h00, 0, 8'hA5, 1, 0);
      add    (1, 20'h00400, 0, 8'h00, 8'h11, 8'h00, 1, 8'h11, 1, 1);
      // Write 0x77 to the latched address updates the latch
      add    (1, 20'h00400, 1, 8'h77, 8'h11, 8'h00, 0, 8'h11, 1, 1);
      add    (1, 20'h00400, 1, 8'h77, 8'h11, 8'h00, 0, 8'h11, 0, 1);
      add    (1, 20'h00400, 1, 8'h77, 8'h11, 8'h00, 0, 8'h11, 0, 1);
      add    (1, 20'h00400, 1, 8'h77, 8'h11, 8'h00, 1, 8'h77, 1, 1);
      add    (1, 20'h00400, 0, 8'h00, 8'hEE, 8'h00, 1, 8'h77, 1, 1);
      // ROM read 0xFFFF0, then discarded ROM write
      add    (1, 20'hFFFF0, 0, 8'h00, 8'hEE, 8'hEA, 0, 8'h77, 1, 1);
      add_bus(1, 20'hFFFF0, 0, 8'h00, 8'hEE, 8'hEA, 0, 8'h77, 1, 1, 20'h00400, 8'h77, 16'hFFF0);
      add    (1, 20'hFFFF0, 0, 8'h00, 8'hEE, 8'h55, 1, 8'hEA, 1, 1);
      add    (1, 20'hFFFF0, 1, 8'h00, 8'hEE, 8'h55, 0, 8'hEA, 1, 1);
      add    (1, 20'hFFFF0, 1, 8'h00, 8'hEE, 8'h55, 1, 8'hEA, 1, 1);
      add_bus(1, 20'hFFFF0, 0, 8'h00, 8'hEE, 8'h55, 1, 8'hEA, 1, 1, 20'h00400, 8'h77, 16'hFFF0);

      reset_n     = 1'b0;
      cpu_address = 20'h12345;
      cpu_out     = 8'h99;
      cpu_we      = 1'b1;
      sram_din    = 8'hA5;
      rom_q       = 8'h00;
      repeat (2) @(posedge clock);
      #1;
      mon_en = 1'b1;

      foreach (vecs[i]) begin
         reset_n     = vecs[i].rst_n;
         cpu_address = vecs[i].addr;
         cpu_we      = vecs[i].we;
         cpu_out     = vecs[i].wdata;
         sram_din    = vecs[i].din;
         rom_q       = vecs[i].romq;
         @(negedge clock);
         check($sformatf("v%0d_chipen", i), 32'(chipen), 32'(vecs[i].e_chipen));
         check($sformatf("v%0d_cpu_in", i), 32'(cpu_in), 32'(vecs[i].e_cpu_in));
         check($sformatf("v%0d_we_n", i), 32'(sram_we_n), 32'(vecs[i].e_we_n));
         check($sformatf("v%0d_oe_n", i), 32'(sram_oe_n), 32'(vecs[i].e_oe_n));
         if (vecs[i].chk_bus) begin
            check($sformatf("v%0d_sram_addr", i), 32'(sram_addr), 32'(vecs[i].e_saddr));
            check($sformatf("v%0d_sram_dout", i), 32'(sram_dout), 32'(vecs[i].e_sdout));
            check($sformatf("v%0d_rom_addr", i), 32'(rom_addr), 32'(vecs[i].e_raddr));
         end
         @(posedge clock);
         #1;
      end

      // Reset during the 2nd SRAM_WR cycle aborts the strobe
      cpu_address = 20'h00800;
      cpu_out     = 8'h42;
      cpu_we      = 1'b1;
      @(negedge clock);
      check("abort_start_chipen", 32'(chipen), 32'(1'b0));
      @(posedge clock);
      #1;
      @(negedge clock);
      check("abort_wr1_we_n", 32'(sram_we_n), 32'(1'b0));
      @(posedge clock);
      #1;
      reset_n = 1'b0;
      @(negedge clock);
      check("abort_rst_chipen", 32'(chipen), 32'(1'b0));
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      @(negedge clock);
      check("abort_post_we_n", 32'(sram_we_n), 32'(1'b1));
      check("abort_post_oe_n", 32'(sram_oe_n), 32'(1'b1));
      check("abort_post_chipen", 32'(chipen), 32'(1'b0));
      check("abort_post_cpu_in", 32'(cpu_in), 32'(8'h00));
      @(posedge clock);
      #1;

      // Held write is reissued in full
      n    = 0;
      wlow = 0;
      @(negedge clock);
      while (chipen !== 1'b1 && n < 20) begin
         if (sram_we_n === 1'b0) wlow++;
         n++;
         @(negedge clock);
      end
      check("reissue_chipen", 32'(chipen), 32'(1'b1));
      check("reissue_stall_cycles", 32'(n), 32'd2);
      check("reissue_we_low_cycles", 32'(wlow), 32'd2);
      check("reissue_sram_addr", 32'(sram_addr), 32'h00800);
      check("reissue_sram_dout", 32'(sram_dout), 32'h42);
      @(posedge clock);
      #1;
      cpu_we = 1'b0;
      mon_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/k8088_memctl.md
Name: k8088_memctl

Overview:
- Memory-side responder for the k8088 CPU bus. The CPU presents a 20-bit address, write data and `we`; this block serves each access and returns read data.
- It stalls the CPU by deasserting `chipen` until the access completes.
- Two regions: an internal boot ROM (synchronous BRAM, 1-cycle latency) and external asynchronous SRAM with configurable wait states.
- A single-entry read latch lets repeated reads of the same address complete with no stall.

Parameters:
- SRAM_WAIT, 2, SRAM access cycles per read/write (legal range 1..15).
- ROM_NIBBLE, 4'hF, value of address[19:16] that selects the ROM region (64 KB).

Ports:
- clock  in  1  system clock, 25 MHz
- reset_n  in  1  synchronous, active-low reset
- cpu_address  in  20  CPU bus address
- cpu_out  in  8  CPU write data
- cpu_we  in  1  CPU write request; held by the CPU while stalled
- cpu_in  out  8  read data to CPU, driven from the read latch
- chipen  out  1  CPU clock enable; 1 = access complete, CPU advances this edge
- rom_addr  out  16  BRAM address
- rom_q  in  8  BRAM data, valid 1 cycle after rom_addr
- sram_addr  out  20  SRAM address (registered)
- sram_dout  out  8  SRAM write data (registered)
- sram_din  in  8  SRAM read data
- sram_we_n  out  1  SRAM write strobe, active low
- sram_oe_n  out  1  SRAM output enable, active low

Behaviour:
- Reset: while reset_n=0 the following hold on the edge:
  - state=IDLE; tag_valid=0, tag_addr=0, tag_data=0; wr_done=0; cnt=0.
  - sram_we_n=1, sram_oe_n=1, sram_addr=0, sram_dout=0, rom_addr=0.
  - cpu_in=0.
  - chipen is forced 0 combinationally; cpu_we is not reset by the CPU and must be ignored.
- Reset mid-operation aborts any access next edge. An SRAM write strobe is never left low past reset.
- Region: rom_sel = (cpu_address[19:16]==ROM_NIBBLE).
- chipen (combinational) = reset_n & state==IDLE & one of:
  - cpu_we & wr_done
  - !cpu_we & tag_valid & cpu_address==tag_addr
- States: IDLE, ROM_RD, SRAM_RD, SRAM_WR.
- IDLE transitions:
  - chipen=1 & cpu_we: clear wr_done; stay IDLE.
  - !cpu_we and miss:
    - Latch tag_addr=cpu_address, tag_valid=0.
    - If rom_sel: rom_addr=address[15:0], go ROM_RD.
    - Else: sram_addr=address, sram_oe_n=0, cnt=SRAM_WAIT-1, go SRAM_RD.
  - cpu_we & !wr_done:
    - If rom_sel: write discarded, set wr_done=1, stay IDLE.
    - Else: sram_addr=address, sram_dout=cpu_out, sram_we_n=0, cnt=SRAM_WAIT-1, go SRAM_WR.
- ROM_RD: tag_data=rom_q, tag_valid=1, go IDLE. Miss latency is 2 stalled cycles; chipen=1 on the 3rd cycle.
- SRAM_RD:
  - cnt!=0: decrement cnt.
  - cnt==0: tag_data=sram_din, tag_valid=1, sram_oe_n=1, go IDLE.
  - Stalled cycles = SRAM_WAIT+1.
- SRAM_WR:
  - cnt!=0: decrement cnt.
  - cnt==0: sram_we_n=1, wr_done=1, go IDLE.
  - sram_we_n is low for exactly SRAM_WAIT cycles; sram_addr/sram_dout are stable the whole strobe and one cycle after it.
- Coherency: a completed write (ROM or SRAM) to an address equal to tag_addr while tag_valid=1 updates the latch.
  - SRAM write: tag_data is set to the written byte.
  - ROM write: the latch is unchanged.
- Latch hits never touch SRAM or ROM. tag_addr compares all 20 bits; no wrap beyond 20 bits.
- sram_we_n and sram_oe_n are never both 0.
- cpu_in = tag_data at all times.

Test Plan:
1. Reset, SRAM_WAIT=2 -> chipen=0, sram_we_n=1, sram_oe_n=1, cpu_in=0 during reset and in the first IDLE cycle with cpu_address=0x12345 (miss).
2. Read 0x12345 with sram_din=0xA5 -> chipen=0 for 3 cycles, sram_oe_n low 2 cycles, then chipen=1 with cpu_in=0xA5. Holding the same address keeps chipen=1 every cycle with no SRAM activity.
3. Write 0x5A to 0x00400 -> sram_we_n low exactly 2 cycles with sram_addr=0x00400, sram_dout=0x5A. chipen=1 for one cycle after. Releasing cpu_we then reading 0x00400 costs a miss and returns sram_din.
4. Read 0x00400 (latched 0x11), then write 0x77 to it -> the subsequent read hits immediately with cpu_in=0x77 and sram_oe_n stays 1.
5. ROM read 0xFFFF0 with rom_q=0xEA -> rom_addr=0xFFF0, 2 stall cycles, chipen=1 with cpu_in=0xEA. Writing 0x00 to 0xFFFF0 -> no sram_we_n pulse, chipen=1 next cycle, latch still 0xEA.
6. Assert reset_n=0 during the 2nd SRAM_WR cycle -> sram_we_n=1 and state=IDLE after that edge. After release, a write is not completed until the CPU reissues it.
